// File: rtl/steer_delta_quad_if.sv
// Steering input bundle: signed movement deltas and digital left/right go in.
// The quadrature pair and the busy flag come back out.
interface steer_delta_quad_if #(
   parameter int unsigned DELTA_W = 8
);
   logic                      delta_strobe;
   logic signed [DELTA_W-1:0] delta;
   logic [1:0]                sens;
   logic                      left;
   logic                      right;
   logic                      clear;
   logic [1:0]                steer;
   logic                      busy;

   modport master (
      output delta_strobe, delta, sens, left, right, clear,
      input  steer, busy
   );

   modport slave (
      input  delta_strobe, delta, sens, left, right, clear,
      output steer, busy
   );
endinterface

// File: rtl/steer_delta_quad.sv
// Relative steering to Gray-coded quadrature. Deltas are scaled and accumulated with saturation.
// The accumulator is drained at one step per STEP_DIV cycles.
module steer_delta_quad #(
   parameter int unsigned STEP_DIV = 22500,
   parameter int unsigned DELTA_W  = 8,
   parameter int unsigned ACC_W    = 12
) (
   input logic              clk_sys,
   input logic              reset,
   steer_delta_quad_if.slave bus
);
   localparam int unsigned TimerW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned SumW   = ACC_W + 4;
   localparam logic signed [SumW-1:0] AccMax = SumW'((2 ** (ACC_W - 1)) - 1);
   localparam logic signed [SumW-1:0] AccMin = -AccMax;

   typedef enum logic [1:0] {
      StPh00 = 2'b00,
      StPh01 = 2'b01,
      StPh11 = 2'b11,
      StPh10 = 2'b10
   } phase_e;

   phase_e                   phase_q, phase_d;
   logic [TimerW-1:0]        timer_q, timer_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     busy_q;
   logic                     tick;
   logic                     acc_pos, acc_neg;
   logic                     step_fwd, step_bwd;
   logic signed [SumW-1:0]   delta_ext, scaled, addend, draw, acc_ext, sum;

   assign tick    = (timer_q == TimerW'(STEP_DIV - 1));
   assign timer_d = tick ? '0 : timer_q + 1'b1;

   assign acc_neg = acc_q[ACC_W-1];
   assign acc_pos = !acc_q[ACC_W-1] && (acc_q != '0);

   // Direction is decided from the pre-update accumulator, so a strobe on the tick
   // cycle cannot influence that same tick.
   always_comb begin
      step_fwd = 1'b0;
      step_bwd = 1'b0;
      draw     = '0;
      if (tick) begin
         if (acc_pos) begin
            step_fwd = 1'b1;
            draw     = SumW'(1);
         end else if (acc_neg) begin
            step_bwd = 1'b1;
            draw     = '1;
         end else if (bus.right && !bus.left) begin
            step_fwd = 1'b1;
         end else if (bus.left && !bus.right) begin
            step_bwd = 1'b1;
         end
      end
   end

   always_comb begin
      delta_ext = {{(SumW - DELTA_W){bus.delta[DELTA_W-1]}}, bus.delta};
      scaled    = delta_ext <<< bus.sens;
      addend    = bus.delta_strobe ? scaled : '0;
      acc_ext   = {{(SumW - ACC_W){acc_q[ACC_W-1]}}, acc_q};
      sum       = acc_ext + addend - draw;
      if (bus.clear) begin
         acc_d = '0;
      end else if (sum > AccMax) begin
         acc_d = AccMax[ACC_W-1:0];
      end else if (sum < AccMin) begin
         acc_d = AccMin[ACC_W-1:0];
      end else begin
         acc_d = sum[ACC_W-1:0];
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         timer_q <= '0;
         acc_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         timer_q <= timer_d;
         acc_q   <= acc_d;
         busy_q  <= (acc_d != '0);
      end
   end

   // Phase machine: state register
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         phase_q <= StPh00;
      end else begin
         phase_q <= phase_d;
      end
   end

   // Phase machine: next state; forward walks 00->01->11->10->00
   always_comb begin
      phase_d = phase_q;
      if (step_fwd) begin
         unique case (phase_q)
            StPh00: phase_d = StPh01;
            StPh01: phase_d = StPh11;
            StPh11: phase_d = StPh10;
            StPh10: phase_d = StPh00;
         endcase
      end else if (step_bwd) begin
         unique case (phase_q)
            StPh00: phase_d = StPh10;
            StPh10: phase_d = StPh11;
            StPh11: phase_d = StPh01;
            StPh01: phase_d = StPh00;
         endcase
      end
   end

   // Phase machine: outputs straight from registers
   always_comb begin
      bus.steer = phase_q;
      bus.busy  = busy_q;
   end
endmodule

// File: doc/steer_delta_quad.md
# steer_delta_quad

Converts relative steering input into the two-phase quadrature pair consumed by the sprint1 core's SteerA_I/SteerB_I. Input comes from signed mouse/spinner deltas or held digital left/right. It sits between the input mapping in the top level and the sprint1 core, running on clk_sys. Deltas are scaled by a sensitivity shift and accumulated with saturation. The accumulator is then drained at a fixed, rate-limited step rate, so the core's quadrature sampler never sees edges faster than it can count.

## Interface
Parameters:
- STEP_DIV, 22500: clk_sys cycles per quadrature step slot; must be ≥ 2.
- DELTA_W, 8: width of signed delta input.
- ACC_W, 12: width of signed step accumulator.

Ports:
- clk_sys  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- delta_strobe  in  1  one-cycle qualifier for delta.
- delta  in  DELTA_W  signed two's-complement movement; positive = right.
- sens  in  2  left-shift applied to delta (×1, ×2, ×4, ×8).
- left  in  1  held digital left.
- right  in  1  held digital right.
- clear  in  1  synchronous flush of accumulator; phase is kept.
- steer  out  2  quadrature {A,B}; bit1 → SteerA_I, bit0 → SteerB_I.
- busy  out  1  high while accumulator ≠ 0.

## Operation
- **Timer.** Counts 0..STEP_DIV-1 and wraps. `tick` is asserted when timer == STEP_DIV-1.
- **Scaling.** `scaled = sign_extend(delta) <<< sens`, computed in ACC_W+4 bits.
- **Step direction on tick:**
  - acc > 0 → forward step.
  - acc < 0 → backward step.
  - acc == 0 and right & ~left → forward step.
  - acc == 0 and left & ~right → backward step.
  - Otherwise no step.
- **Step count.** `s` = +1 for a forward step drawn from acc, −1 for a backward step drawn from acc, 0 otherwise. Digital-joystick steps do not touch acc.
- **Accumulator update.** `acc_next = sat(acc + (delta_strobe ? scaled : 0) − s)`.
  - Saturation range is [−(2^(ACC_W−1)−1), +(2^(ACC_W−1)−1)]: ±2047 at the default width.
  - The most-negative code is never produced.
- **Phase machine.** Four states, Gray-coded on steer.
  - Forward: 00→01→11→10→00.
  - Backward: the reverse order.
  - At most one transition per tick, so only one bit changes per step.
- **clear.** Has priority over delta_strobe and the acc update: acc ← 0 in the same cycle.
  - A tick coinciding with clear still performs a joystick step if left/right qualify.
- **busy.** Registered, equal to (acc ≠ 0) after the update.

## Timing
- **Reset values:** steer = 00, busy = 0, acc = 0, timer = 0.
- **Reset mid-operation:** same reset values apply; pending accumulated steps are discarded.
- **Step latency.**
  - The phase changes on the clock edge where tick is high; the new steer is visible the following cycle.
  - Minimum step-to-step spacing is exactly STEP_DIV cycles.
- **Delta latency.** A delta strobed in cycle n is reflected in acc/busy at cycle n+1.
  - Its first step occurs at the next tick, 1..STEP_DIV cycles later.
  - A strobe on the tick cycle itself does not contribute to that tick's direction decision.
- **Simultaneous strobe + tick:** both applied in one update, per the formula above.
- **Direction reversal.** If acc changes sign because a large opposite delta arrives, the next tick steps in the new direction. The phase reverses along the Gray sequence with no skipped state.
- **Both left and right held with acc == 0:** no step; phase holds.
- **Saturation:** further same-sign deltas are dropped silently; opposite-sign deltas apply normally from the clamped value.
- **Outputs:** steer and busy are registered; there is no combinational path from any input to any output.

## Test plan
- **Reset / idle:** STEP_DIV=4, assert reset 3 cycles, then run 40 cycles idle → steer stays 00, busy 0.
- **Positive delta:** delta=+3, sens=0, one strobe.
  - steer goes 00→01→11→10 on three consecutive ticks, 4 cycles apart.
  - busy drops the cycle after the third step.
  - No further change.
- **Negative delta with sens:** delta=−1, sens=2 → acc=−4.
  - Four backward steps: 00→10→11→01→00.
- **Saturation and reversal:** three strobes of +127 with sens=3 → acc clamps at 2047.
  - Then strobe −128, sens=3 → acc=1023; stepping continues forward.
  - Then clear → acc 0, busy 0, steer holds its last value.
- **Simultaneous:** strobe delta=+1 on a tick cycle while acc=−1.
  - That tick steps backward (acc→0); the strobe then leaves acc=+1 (combined update = −1+1+1).
  - The next tick steps forward.
- **Joystick:**
  - right held 20 cycles (STEP_DIV=4, acc=0) → 5 forward steps.
  - left+right held → no steps.
  - Reset asserted mid-hold → steer 00 the next cycle.
